// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared types and helpers for the stream_demux block.
//   - state_t     : packet-lock FSM states (used only when STREAM_DEMUX_PKT_LOCK_EN
//                   is defined in the top module).
//   - sel_width_f : width of a select field able to address n channels.
package stream_demux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // A single channel still needs a 1-bit select so the port never collapses
  // to zero width.
  function automatic int sel_width_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_slice.sv
// stream_demux_slice
//   One-entry valid/ready output register holding a beat (data + last) for a
//   single demux channel.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     load                write load_data/load_last this cycle
//     load_data/last      beat to store
//     out_ready           downstream consumer ready
//     out_data/last/valid registered channel outputs
//   A load takes priority over a drain, so a simultaneous load and drain keeps
//   out_valid high with the new beat. Data/last hold their value while idle.
module stream_demux_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      last_d  = load_last;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux
//   Registered, flow-controlled 1-to-NUM_OUTPUTS stream demultiplexer. Each
//   channel has a one-entry output register with its own backpressure. Beats
//   addressed to a nonexistent channel are accepted, discarded and counted.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     in_data/in_sel/in_last/in_valid/in_ready   input stream
//     out_data[NUM_OUTPUTS], out_last, out_valid, out_ready  per-channel streams
//     drop_pulse      one-cycle pulse per discarded beat
//     drop_cnt        saturating count of discarded beats
//   Optional feature: define STREAM_DEMUX_PKT_LOCK_EN to enable packet lock,
//   where the select of a packet's first beat routes the whole packet.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OUTPUTS = 16,
  parameter int SEL_WIDTH   = sel_width_f(NUM_OUTPUTS),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SEL_WIDTH-1:0]   in_sel,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data [NUM_OUTPUTS],
  output logic [NUM_OUTPUTS-1:0] out_last,
  output logic [NUM_OUTPUTS-1:0] out_valid,
  input  logic [NUM_OUTPUTS-1:0] out_ready,
  output logic                   drop_pulse,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);

  logic [SEL_WIDTH-1:0]   tgt;        // effective target channel
  logic [NUM_OUTPUTS-1:0] hit;        // one-hot decode of tgt; all-zero if out of range
  logic [NUM_OUTPUTS-1:0] chan_ready; // channel can take a beat this cycle
  logic [NUM_OUTPUTS-1:0] load;
  logic                   in_range;
  logic                   accept;
  logic                   drop;

  // ---------------------------------------------------------------------------
  // Target selection
  // ---------------------------------------------------------------------------
`ifdef STREAM_DEMUX_PKT_LOCK_EN
  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_sel_q, lock_sel_d;

  // Inside a packet the latched select wins; in_sel is ignored until the
  // last beat has been accepted.
  assign tgt = (state_q == IN_PKT) ? lock_sel_q : in_sel;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d    = IN_PKT;
            lock_sel_d = in_sel;
          end
        end
        IN_PKT: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end
`else
  // Every beat is routed by its own select; in_last is only carried through.
  assign tgt = in_sel;
`endif

  // ---------------------------------------------------------------------------
  // Decode, handshake and channel registers
  // ---------------------------------------------------------------------------
  // Decoding against each existing channel index gives the range check for
  // free: a select beyond NUM_OUTPUTS-1 matches no channel.
  assign in_range = |hit;
  assign in_ready = in_range ? |(hit & chan_ready) : 1'b1;
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !in_range;
  assign load     = hit & {NUM_OUTPUTS{accept}};

  generate
    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_chan
      assign hit[gi]        = (tgt == SEL_WIDTH'(gi));
      assign chan_ready[gi] = !out_valid[gi] || out_ready[gi];

      stream_demux_slice #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[gi]),
        .load_data (in_data),
        .load_last (in_last),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi]),
        .out_last  (out_last[gi]),
        .out_valid (out_valid[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------------
  logic                 drop_pulse_q, drop_pulse_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_pulse_d = drop;
    drop_cnt_d   = drop_cnt_q;
    // Saturate at all-ones rather than wrapping back to zero.
    if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux
//   Scoreboard bench for stream_demux with 12 channels and a 2-bit drop
//   counter. Stimulus pushes expected beats per channel (and expected drop
//   pulses); a forked monitor pops and compares on every output handshake.
//   Packet-lock expectations follow STREAM_DEMUX_PKT_LOCK_EN.
module tb_stream_demux;

  localparam int DW = 8;
  localparam int NO = 12;
  localparam int SW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data [NO];
  logic [NO-1:0] out_last;
  logic [NO-1:0] out_valid;
  logic [NO-1:0] out_ready;
  logic          drop_pulse;
  logic [CW-1:0] drop_cnt;

  stream_demux #(
    .DATA_WIDTH  (DW),
    .NUM_OUTPUTS (NO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int            checks = 0;
  int            errors = 0;
  logic [DW:0]   exp_q [NO][$];   // {last, data} per channel
  int            drop_q [$];      // one entry per expected drop_pulse
  int            exp_drop_cnt = 0;
  logic          lock_active = 1'b0;
  logic [SW-1:0] lock_sel = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pops and compares every channel handshake and every drop pulse.
  task automatic monitor();
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NO; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_beat ch=%0d actual=%0h required=none", i, {out_last[i], out_data[i]});
            end else begin
              e = exp_q[i].pop_front();
              if ({out_last[i], out_data[i]} !== e) begin
                errors++;
                $display("FAIL beat ch=%0d actual=%0h required=%0h", i, {out_last[i], out_data[i]}, e);
              end else begin
                $display("beat ch=%0d data=%02h last=%0b", i, out_data[i], out_last[i]);
              end
            end
          end
        end
        if (drop_pulse) begin
          checks++;
          if (drop_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_drop_pulse actual=1 required=0");
          end else begin
            void'(drop_q.pop_front());
            $display("drop pulse cnt=%0d", drop_cnt);
          end
        end
      end
    end
  endtask

  // Presents one beat, waits (bounded) for acceptance and records the
  // expected outcome from the bench's own routing model.
  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    int t_ch;
    int waitc;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = 1'b1;
    t_ch = int'(s);
`ifdef STREAM_DEMUX_PKT_LOCK_EN
    if (lock_active) t_ch = int'(lock_sel);
`endif
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout sel=%0d actual=in_ready0 required=in_ready1", s);
    end else begin
      if (t_ch < NO) begin
        exp_q[t_ch].push_back({l, d});
      end else begin
        drop_q.push_back(1);
        if (exp_drop_cnt < 3) exp_drop_cnt++;
      end
`ifdef STREAM_DEMUX_PKT_LOCK_EN
      if (!lock_active && !l) begin
        lock_active = 1'b1;
        lock_sel    = s;
      end else if (lock_active && l) begin
        lock_active = 1'b0;
      end
`endif
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int waitc;
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = '1;
    fork
      monitor();
    join_none

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_drop_pulse", 32'(drop_pulse), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < NO; i++) check("rst_out_data", 32'(out_data[i]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single beat, one-cycle latency
    send(8'hA5, 4'd3, 1'b1);
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid), 32'h008);
    check("lat_out_data3", 32'(out_data[3]), 32'hA5);
    @(posedge clk);
    #1;

    // Backpressure on channel 5
    out_ready[5] = 1'b0;
    send(8'h11, 4'd5, 1'b0);
    in_data  = 8'h22;
    in_sel   = 4'd5;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_hold_valid", 32'(out_valid[5]), 1);
      check("bp_hold_data", 32'(out_data[5]), 32'h11);
    end
    @(posedge clk);
    #1;
    out_ready[5] = 1'b1;
    send(8'h22, 4'd5, 1'b1);

    // Out-of-range drops and counter saturation
    send(8'h01, 4'd14, 1'b0);
    send(8'h02, 4'd3, 1'b0);  // dropped only while a locked packet is in flight
    send(8'h03, 4'd14, 1'b1);
    @(negedge clk);
    check("drop_cnt_a", 32'(drop_cnt), 32'(exp_drop_cnt));
    @(posedge clk);
    #1;
    send(8'h04, 4'd13, 1'b1);
    send(8'h05, 4'd15, 1'b1);
    send(8'h06, 4'd12, 1'b1);
    @(negedge clk);
    check("drop_cnt_sat", 32'(drop_cnt), 3);
    @(posedge clk);
    #1;

    // Full-rate streaming to channel 0
    t0 = cycle;
    for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), 4'd0, (i == 5));
    check("stream_cycles", 32'(cycle - t0), 6);

    // Four-beat packet with changing select, then a fresh packet
    send(8'hC0, 4'd2, 1'b0);
    send(8'hC1, 4'd7, 1'b0);
    send(8'hC2, 4'd7, 1'b0);
    send(8'hC3, 4'd7, 1'b1);
    send(8'hD0, 4'd4, 1'b1);

    // Asynchronous reset mid-packet with channel 1 full
    out_ready[1] = 1'b0;
    send(8'h33, 4'd1, 1'b0);
    @(negedge clk);
    check("pre_rst_valid1", 32'(out_valid[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_data1", 32'(out_data[1]), 0);
    check("arst_out_last", 32'(out_last), 0);
    check("arst_drop_cnt", 32'(drop_cnt), 0);
    exp_q[1].delete();
    drop_q.delete();
    exp_drop_cnt = 0;
    lock_active  = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = '1;
    send(8'h44, 4'd6, 1'b1);
    @(negedge clk);
    check("post_rst_route", 32'(out_valid), 32'h040);
    @(posedge clk);
    #1;

    // Drain and confirm nothing is outstanding
    waitc = 0;
    while (waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    for (int i = 0; i < NO; i++) check("leftover_beats", 32'(exp_q[i].size()), 0);
    check("leftover_drops", 32'(drop_q.size()), 0);
    check("final_drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
